// File: rtl/output_buffer_ctrl_pkg.sv
// Shared types and defaults for the output_buffer sequencer.
package output_buffer_ctrl_pkg;

  // Defaults used when the shared configuration does not override them.
  localparam int DEFAULT_ARRAYWIDTH = 8;
  localparam int DEFAULT_DSP_DELAY  = 3;

  // Tile sequencing states.
  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_WAIT  = 3'd1,
    ST_LOAD  = 3'd2,
    ST_DRAIN = 3'd3,
    ST_DONE  = 3'd4,
    ST_CLR   = 3'd5
  } state_t;

  // Counter width that stays at least one bit wide for degenerate sizes.
  function automatic int cnt_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/output_buffer_ctrl.sv
// Sequencer for the systolic array output_buffer: waits for the first
// result row, loads every lane, drains rows over valid/ready, then clears
// the buffer before the next tile.
module output_buffer_ctrl
  import output_buffer_ctrl_pkg::*;
#(
  parameter int ARRAYWIDTH = DEFAULT_ARRAYWIDTH,
  parameter int DSP_DELAY  = DEFAULT_DSP_DELAY
) (
  input  logic clk,
  input  logic rst,
  input  logic start,
  input  logic abort,
  input  logic res_valid,
  input  logic out_ready,
  output logic load_en,
  output logic out_en,
  output logic out_valid,
  output logic out_last,
  output logic buf_rst,
  output logic busy,
  output logic done
);

  // The load phase lasts one lane-enable step per lane.
  localparam int LOAD_CYCLES = ARRAYWIDTH * DSP_DELAY;
  localparam int LW          = $clog2(LOAD_CYCLES + 1);
  localparam int RW          = cnt_width(ARRAYWIDTH);

  localparam logic [LW-1:0] LOAD_LAST = LW'(LOAD_CYCLES - 1);
  localparam logic [LW-1:0] LOAD_MAX  = LW'(LOAD_CYCLES);
  localparam logic [RW-1:0] ROW_LAST  = RW'(ARRAYWIDTH - 1);

  state_t        state_q, state_d;
  logic [LW-1:0] load_cnt_q, load_cnt_d;
  logic [RW-1:0] row_cnt_q, row_cnt_d;
  logic          load_en_q, load_en_d;
  logic          out_valid_q, out_valid_d;
  logic          done_q, done_d;
  logic          buf_rst_q, buf_rst_d;
  logic          abort_hit;
  logic          handshake;
  logic          row_is_last;

  // A row moves downstream whenever it is offered and accepted this cycle.
  assign handshake   = out_valid_q & out_ready;
  assign row_is_last = (row_cnt_q == ROW_LAST);

  // Next-state and counter updates; abort overrides every other transition.
  always_comb begin
    // NOTE: every signal assigned here gets a default first so no path
    // leaves it unassigned, which would otherwise infer a latch.
    state_d    = state_q;
    load_cnt_d = load_cnt_q;
    row_cnt_d  = row_cnt_q;
    abort_hit  = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (start) state_d = ST_WAIT;
      end
      ST_WAIT: begin
        if (res_valid) state_d = ST_LOAD;
      end
      ST_LOAD: begin
        if (load_cnt_q == LOAD_LAST) begin
          state_d    = ST_DRAIN;
          load_cnt_d = '0;
        end else if (load_cnt_q < LOAD_MAX) begin
          load_cnt_d = load_cnt_q + 1'b1;
        end
      end
      ST_DRAIN: begin
        if (handshake) begin
          if (row_is_last) begin
            state_d   = ST_DONE;
            row_cnt_d = '0;
          end else begin
            row_cnt_d = row_cnt_q + 1'b1;
          end
        end
      end
      ST_DONE: state_d = ST_CLR;
      ST_CLR:  state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase

    if (abort && (state_q != ST_IDLE)) begin
      state_d    = ST_CLR;
      load_cnt_d = '0;
      row_cnt_d  = '0;
      abort_hit  = 1'b1;
    end
  end

  // Registered outputs are decoded from the upcoming state so they line up
  // with the state they qualify.
  always_comb begin
    load_en_d   = (state_d == ST_LOAD);
    out_valid_d = (state_d == ST_DRAIN);
    done_d      = (state_d == ST_DONE);
    buf_rst_d   = (state_d == ST_DONE) | abort_hit;
  end

  // State, counters and registered outputs; buf_rst comes out of reset high
  // so the buffer always sees at least one clear cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      load_cnt_q  <= '0;
      row_cnt_q   <= '0;
      load_en_q   <= 1'b0;
      out_valid_q <= 1'b0;
      done_q      <= 1'b0;
      buf_rst_q   <= 1'b1;
    end else begin
      // NOTE: non-blocking assignments keep every register sampling the
      // pre-edge values, independent of statement order.
      state_q     <= state_d;
      load_cnt_q  <= load_cnt_d;
      row_cnt_q   <= row_cnt_d;
      load_en_q   <= load_en_d;
      out_valid_q <= out_valid_d;
      done_q      <= done_d;
      buf_rst_q   <= buf_rst_d;
    end
  end

  assign load_en   = load_en_q;
  assign out_valid = out_valid_q;
  assign out_en    = handshake;
  assign out_last  = out_valid_q & row_is_last;
  assign buf_rst   = buf_rst_q;
  assign done      = done_q;
  assign busy      = (state_q != ST_IDLE);

endmodule

// File: tb/tb_output_buffer_ctrl.sv
// Self-checking bench for output_buffer_ctrl with ARRAYWIDTH=4, DSP_DELAY=3.
module tb_output_buffer_ctrl;

  localparam int AW     = 4;
  localparam int DD     = 3;
  localparam int LOADS  = AW * DD;
  localparam int PERIOD = LOADS + AW + 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic start = 1'b0, abort = 1'b0, res_valid = 1'b0, out_ready = 1'b0;
  logic load_en, out_en, out_valid, out_last, buf_rst, busy, done;

  int n_checks = 0;
  int n_errors = 0;

  // One cycle of stimulus plus the expected outputs for that cycle, packed
  // as {load_en, out_en, out_valid, out_last, buf_rst, busy, done}.
  typedef struct {
    logic       start;
    logic       abort;
    logic       res_valid;
    logic       out_ready;
    logic [6:0] exp;
  } vec_t;

  vec_t vecs[$];

  output_buffer_ctrl #(.ARRAYWIDTH(AW), .DSP_DELAY(DD)) dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort),
    .res_valid(res_valid), .out_ready(out_ready),
    .load_en(load_en), .out_en(out_en), .out_valid(out_valid),
    .out_last(out_last), .buf_rst(buf_rst), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [6:0] outs();
    return {load_en, out_en, out_valid, out_last, buf_rst, busy, done};
  endfunction

  function automatic void add(input logic s, input logic a, input logic rv,
                              input logic rd, input logic [6:0] e);
    vec_t v;
    v.start = s; v.abort = a; v.res_valid = rv; v.out_ready = rd; v.exp = e;
    vecs.push_back(v);
  endfunction

  task automatic tick();
    @(negedge clk);
  endtask

  // Runs one tile from IDLE with res_valid/out_ready high; optionally pokes
  // start while loading/draining. Returns per-output activity counts.
  task automatic run_tile(input string tag, input bit poke_start,
                          output int loads, output int rows,
                          output int lasts, output int dones);
    int  n;
    bit  seen;
    loads = 0; rows = 0; lasts = 0; dones = 0; n = 0; seen = 1'b0;
    res_valid = 1'b1; out_ready = 1'b1; start = 1'b1;
    while (n < 100) begin
      #1;
      if (load_en) loads++;
      if (out_en) rows++;
      if (out_last && out_en) lasts++;
      if (done) begin dones++; seen = 1'b1; end
      tick();
      n++;
      start = poke_start && (load_en || out_valid);
      if (seen && !busy) break;
    end
    start = 1'b0;
    if (n >= 100) check({tag, "_timeout"}, 0, 1);
  endtask

  task automatic wait_valid(input string tag);
    int n;
    n = 0;
    while (!out_valid && n < 60) begin tick(); n++; end
    if (n >= 60) check({tag, "_wait_valid_timeout"}, 0, 1);
  endtask

  initial begin
    int loads, rows, lasts, dones;
    int t_done[$];
    int cyc;

    // Tile 1: start, res_valid 5 cycles later, then a stalling drain.
    add(1, 0, 0, 0, 7'b0000000);                       // IDLE, start sampled
    for (int i = 0; i < 4; i++) add(0, 0, 0, 0, 7'b0000010); // WAIT
    add(0, 0, 1, 0, 7'b0000010);                       // WAIT, res_valid
    for (int i = 0; i < LOADS; i++) add(0, 0, 0, 0, 7'b1000010); // LOAD
    add(0, 0, 0, 1, 7'b0110010);                       // row 0
    add(0, 0, 0, 0, 7'b0010010);                       // stall
    add(0, 0, 0, 0, 7'b0010010);                       // stall
    add(0, 0, 0, 1, 7'b0110010);                       // row 1
    add(0, 0, 0, 0, 7'b0010010);                       // stall
    add(0, 0, 0, 1, 7'b0110010);                       // row 2
    add(0, 0, 0, 1, 7'b0111010);                       // row 3, last
    add(0, 0, 0, 0, 7'b0000111);                       // DONE
    add(0, 0, 0, 0, 7'b0000010);                       // CLR
    add(0, 0, 0, 0, 7'b0000000);                       // IDLE

    // Reset state and release.
    #12;
    check("reset_outputs", outs(), 7'b0000100);
    tick();
    rst = 1'b0;
    #1 check("buf_rst_before_edge", buf_rst, 1);
    tick();
    check("buf_rst_after_edge", buf_rst, 0);
    check("abort_in_idle_busy", busy, 0);

    // Table-driven tile.
    foreach (vecs[i]) begin
      start = vecs[i].start; abort = vecs[i].abort;
      res_valid = vecs[i].res_valid; out_ready = vecs[i].out_ready;
      #1 check($sformatf("vec[%0d]", i), outs(), vecs[i].exp);
      tick();
    end

    // Abort on the 6th load cycle, then a clean tile.
    start = 1'b1; res_valid = 1'b1; out_ready = 1'b1;
    tick(); start = 1'b0;                // now WAIT
    tick();                              // 1st load cycle
    for (int i = 1; i < 6; i++) tick();  // 6th load cycle
    #1 check("abort_pre_load_en", load_en, 1);
    abort = 1'b1;
    tick(); abort = 1'b0;
    #1 check("abort_clr_outputs", outs(), 7'b0000110);
    tick();
    #1 check("abort_back_idle", outs(), 7'b0000000);
    run_tile("after_abort", 0, loads, rows, lasts, dones);
    check("after_abort_loads", loads, LOADS);
    check("after_abort_rows", rows, AW);
    check("after_abort_dones", dones, 1);

    // Handshake and abort in the same cycle: shift happens, tile cancelled.
    start = 1'b1; res_valid = 1'b1; out_ready = 1'b1;
    tick(); start = 1'b0;
    wait_valid("hs_abort");
    tick();                              // row 0 taken
    abort = 1'b1;
    #1 check("hs_abort_out_en", out_en, 1);
    tick(); abort = 1'b0;
    #1 check("hs_abort_clr", outs(), 7'b0000110);
    tick();
    run_tile("after_hs_abort", 0, loads, rows, lasts, dones);
    check("after_hs_abort_rows", rows, AW);
    check("after_hs_abort_lasts", lasts, 1);

    // start pulses during LOAD and DRAIN are ignored.
    run_tile("start_poke", 1, loads, rows, lasts, dones);
    check("start_poke_dones", dones, 1);
    check("start_poke_rows", rows, AW);
    tick(); tick();
    check("start_poke_no_requeue", busy, 0);

    // Asynchronous reset mid-DRAIN.
    start = 1'b1; res_valid = 1'b1; out_ready = 1'b1;
    tick(); start = 1'b0;
    wait_valid("rst_mid");
    tick();
    #2 rst = 1'b1;
    #1 check("rst_async_outputs", outs(), 7'b0000100);
    tick(); rst = 1'b0;
    #1 check("rst_release_buf_rst", buf_rst, 1);
    tick();
    check("rst_release_edge", buf_rst, 0);
    run_tile("after_rst", 0, loads, rows, lasts, dones);
    check("after_rst_rows", rows, AW);
    check("after_rst_lasts", lasts, 1);

    // Back-to-back tiles with everything tied high.
    start = 1'b1; res_valid = 1'b1; out_ready = 1'b1;
    loads = 0; rows = 0; lasts = 0; cyc = 0;
    while (t_done.size() < 3 && cyc < 200) begin
      #1;
      if (load_en) loads++;
      if (out_en) rows++;
      if (out_en && out_last) lasts++;
      if (done) t_done.push_back(cyc);
      tick();
      cyc++;
    end
    start = 1'b0;
    check("b2b_tiles_seen", t_done.size(), 3);
    if (t_done.size() == 3) begin
      check("b2b_period_1", t_done[1] - t_done[0], PERIOD);
      check("b2b_period_2", t_done[2] - t_done[1], PERIOD);
    end
    check("b2b_rows", rows, 3 * AW);
    check("b2b_lasts", lasts, 3);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/output_buffer_ctrl.md
Name: output_buffer_ctrl

Overview:
Sequencer for the output_buffer of the systolic array.
- Waits for the array to signal that the first result row is valid.
- Drives load_en for exactly the cycles needed to fill every lane's shifter_register.
- Drains the tile row-by-row to a downstream consumer using valid/ready.
- Re-arms the buffer between tiles with a one-cycle synchronous clear, because the buffer's lane-enable mask only clears on its rst.

Parameters:
- ARRAYWIDTH, default `ARRAYWIDTH (8): lanes (columns) in output_buffer. Also the number of rows drained per tile.
- DSP_DELAY, default `DSP_DELAY (3): cycles per lane-enable step inside output_buffer.
- LOAD_CYCLES, default ARRAYWIDTH*DSP_DELAY: derived, not overridable. Length of the load phase.

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  begin one tile; sampled only in IDLE.
- abort  in  1  cancel the current tile from any state.
- res_valid  in  1  array's first result row is present on in_res.
- out_ready  in  1  downstream accepts a row this cycle.
- load_en  out  1  to output_buffer.load_en.
- out_en  out  1  to output_buffer.out_en; one shift per asserted cycle.
- out_valid  out  1  out_res row is valid.
- out_last  out  1  qualifies the final row of the tile (with out_valid).
- buf_rst  out  1  synchronous clear to output_buffer.rst.
- busy  out  1  state != IDLE.
- done  out  1  one-cycle pulse at tile completion.

Behaviour:
- Clock and reset: one clock, clk. Reset rst is asynchronous and active-high.
- Reset values: state IDLE, counters 0, load_en 0, out_valid 0, done 0, buf_rst 1.
  - buf_rst deasserts on the first clk edge after rst falls. This guarantees output_buffer sees at least one clear cycle.
- States: IDLE, WAIT, LOAD, DRAIN, DONE, CLR.
- IDLE:
  - start=1 -> WAIT.
  - start in any other state is ignored, with no queuing.
- WAIT:
  - res_valid=1 -> LOAD.
  - load_en rises on the same edge: it is registered and equal to (next_state==LOAD).
- LOAD:
  - load_en=1 for exactly LOAD_CYCLES consecutive cycles, counted by load_cnt (width clog2(LOAD_CYCLES+1)).
  - Exits to DRAIN when the last load cycle completes. res_valid is not re-checked here.
- DRAIN:
  - out_valid=1, registered.
  - out_en = out_valid & out_ready, combinational, so there are no bubbles when out_ready is held high.
  - row_cnt increments on each handshake. out_last = out_valid & (row_cnt==ARRAYWIDTH-1).
  - Handshake with out_last -> DONE.
  - out_ready=0 stalls with out_valid held; no shift occurs.
- DONE: done=1 and buf_rst=1 for one cycle -> CLR.
- CLR: one idle cycle so output_buffer's internal delay counter reloads -> IDLE.
  - Minimum start-to-start period: LOAD_CYCLES + ARRAYWIDTH + 4 cycles, with res_valid and out_ready tied high.
- abort=1 in any non-IDLE state:
  - Next cycle: state CLR, buf_rst=1, load_en=0, out_valid=0, done=0.
  - Counters clear.
  - abort in IDLE has no effect.
- Simultaneous events:
  - abort beats every other transition.
  - A handshake and abort in the same cycle: the shift happens (out_en is combinational), then the tile is cancelled.
- Reset mid-tile: everything returns to reset values immediately. Data in output_buffer is discarded via buf_rst.
- Width rules:
  - load_cnt saturates and never wraps.
  - row_cnt width is clog2(ARRAYWIDTH); its compare uses ARRAYWIDTH-1 exactly.

Decomposition:
- `ARRAYWIDTH, `DSP_DELAY and `OUTPUT_BUF_DATASIZE come from the shared config include.
- State encodings are localparams in this module.
- Sub-module: none required. A single FSM plus two counters is sufficient.
- A top wrapper output_stage instantiates output_buffer_ctrl and output_buffer side by side. That wrapper is outside this block's scope.

Test Plan:
- ARRAYWIDTH=4, DSP_DELAY=3; rst released, start, res_valid 5 cycles later, out_ready=1 -> load_en high exactly 12 cycles; 4 out_en cycles; out_last on the 4th; done pulse; buf_rst high 1 cycle; busy low 2 cycles after done.
- Same setup, out_ready toggling 1,0,0,1,0,1,1 -> exactly 4 handshakes; out_valid never drops while stalled; out_en=0 whenever out_ready=0.
- abort asserted on the 6th load cycle -> next cycle load_en=0, buf_rst=1, CLR then IDLE; no done pulse; a following tile completes normally.
- start pulsed during LOAD and DRAIN -> ignored; exactly one done pulse.
- rst asserted asynchronously mid-DRAIN (between edges) -> out_valid=0 and buf_rst=1 immediately; after release, buf_rst=0 after one edge and a new tile produces the correct 4 rows.
- Back-to-back tiles with start, res_valid and out_ready tied high -> period = 12+4+4 = 20 cycles; data rows match the array model bit-exactly for 3 tiles.
